// File: rtl/rs232_rx_if.sv
// Byte handshake between the RS-232 receiver and the processor-side consumer.
interface rs232_rx_if;
  logic [7:0] data_out;
  logic       data_ready;
  logic       data_ack;
  logic       overrun;
  logic       frame_err;

  modport master (
    output data_out,
    output data_ready,
    output overrun,
    output frame_err,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_ready,
    input  overrun,
    input  frame_err,
    output data_ack
  );
endinterface

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: oversamples rxd at 8x baud, decides each bit by a
// 3-sample majority vote and hands bytes over through a ready/ack handshake.
module rs232_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_en,
  input  logic          rxd,
  rs232_rx_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  state_t     state;
  logic [2:0] phase;
  logic [2:0] bitidx;
  logic [7:0] shreg;
  logic       samp3;
  logic       samp4;

  logic       maj;
  logic       stop_tick;
  logic       publish;
  logic       stop_bad;

  logic [7:0] data_out_q;
  logic       data_ready_q;
  logic       overrun_q;
  logic       frame_err_q;

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // The phase-5 sample is taken straight from rxd_s so the vote completes on that tick.
  assign maj       = (samp3 & samp4) | (samp3 & rxd_s) | (samp4 & rxd_s);
  assign stop_tick = rx_en && (state == STOP) && (phase == 3'd5);
  assign publish   = stop_tick && maj;
  assign stop_bad  = stop_tick && !maj;

  assign bus.data_out   = data_out_q;
  assign bus.data_ready = data_ready_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

  // Bring the asynchronous line into the clk domain; idles high out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  // Frame FSM, bit-phase counter and mid-bit sampling, advanced only on rx_en ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= 3'd0;
      bitidx <= 3'd0;
      shreg  <= 8'h00;
      samp3  <= 1'b0;
      samp4  <= 1'b0;
    end else if (rx_en) begin
      if (phase == 3'd3) begin
        samp3 <= rxd_s;
      end
      if (phase == 3'd4) begin
        samp4 <= rxd_s;
      end
      case (state)
        IDLE: begin
          phase <= 3'd0;
          if (!rxd_s) begin
            state <= START;
            phase <= 3'd1;
          end
        end
        START: begin
          if ((phase == 3'd5) && maj) begin
            state <= IDLE;
            phase <= 3'd0;
          end else if (phase == 3'd7) begin
            state  <= DATA;
            bitidx <= 3'd0;
            phase  <= 3'd0;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        DATA: begin
          phase <= phase + 3'd1;
          if (phase == 3'd5) begin
            shreg <= {maj, shreg[7:1]};
          end
          if (phase == 3'd7) begin
            if (bitidx == 3'd7) begin
              state <= STOP;
            end else begin
              bitidx <= bitidx + 3'd1;
            end
          end
        end
        STOP: begin
          if (phase == 3'd5) begin
            state <= IDLE;
            phase <= 3'd0;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          phase <= 3'd0;
        end
      endcase
    end
  end

  // Consumer handshake on every clk: publish, acknowledge, overrun and framing-error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= 8'h00;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      if (publish) begin
        data_out_q   <= shreg;
        data_ready_q <= 1'b1;
        overrun_q    <= data_ready_q && !bus.data_ack;
      end else if (bus.data_ack && data_ready_q) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: 8N1 frames at 72 clk per bit with rx_en every
// 9 clk, expected bytes queued on send and popped when the frame completes.
module tb_rs232_rx;

  logic clk;
  logic reset;
  logic rx_en;
  logic rxd;

  int checks = 0;
  int errors = 0;
  int fe_pulses = 0;

  logic [7:0] exp_q[$];

  rs232_rx_if bus ();

  rs232_rx #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_en (rx_en),
    .rxd   (rxd),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle rx_en every 9 clk, changed 1 ns after the edge.
  initial begin
    rx_en = 1'b0;
    forever begin
      repeat (8) @(posedge clk);
      #1 rx_en = 1'b1;
      @(posedge clk);
      #1 rx_en = 1'b0;
    end
  end

  // Count every clk that frame_err is seen high.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_pulses <= fe_pulses + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_data_out"},   bus.data_out,   8'h00);
    check_output({tag, "_data_ready"}, bus.data_ready, 1'b0);
    check_output({tag, "_overrun"},    bus.overrun,    1'b0);
    check_output({tag, "_frame_err"},  bus.frame_err,  1'b0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    reset = 1'b0;
  endtask

  task automatic ack_byte();
    @(posedge clk);
    #1 check_output("ready_before_ack", bus.data_ready, 1'b1);
    bus.data_ack = 1'b1;
    @(posedge clk);
    #1 bus.data_ack = 1'b0;
    check_output("ready_after_ack", bus.data_ready, 1'b0);
    check_output("overrun_after_ack", bus.overrun, 1'b0);
  endtask

  // Drives one frame aligned one cycle after an rx_en tick P; the stop bit is
  // decided at the tick on edge P+702, so outputs move between c=701 and c=702.
  task automatic apply_stimulus(input logic [7:0] d, input logic stop_val, input bit chk,
                                input bit ack_at_pub, input int rst_at);
    logic [9:0] f;
    bit aborted;
    bit good;
    logic [7:0] exp_byte;
    f = {stop_val, d, 1'b0};
    aborted = 1'b0;
    good = stop_val && (rst_at == 0);
    if (good) exp_q.push_back(d);
    @(posedge clk);
    while (rx_en !== 1'b1) @(posedge clk);
    #1 rxd = 1'b0;
    for (int c = 1; c < 720; c++) begin
      @(posedge clk);
      #1;
      rxd = aborted ? 1'b1 : f[c/72];
      if (chk) begin
        if (c == 701) begin
          check_output("ready_before_stop_tick", bus.data_ready, 1'b0);
          check_output("ferr_before_stop_tick", bus.frame_err, 1'b0);
        end
        if (c == 702) begin
          check_output("ready_after_stop_tick", bus.data_ready, stop_val);
          check_output("ferr_after_stop_tick", bus.frame_err, !stop_val);
        end
        if (c == 703) check_output("ferr_one_cycle", bus.frame_err, 1'b0);
      end
      if (ack_at_pub) begin
        if (c == 701) bus.data_ack = 1'b1;
        if (c == 702) bus.data_ack = 1'b0;
      end
      if (rst_at != 0) begin
        if (c == rst_at) reset = 1'b1;
        if (c == rst_at + 2) check_reset_values("midframe_reset");
        if (c == rst_at + 4) begin
          reset = 1'b0;
          aborted = 1'b1;
          rxd = 1'b1;
        end
      end
    end
    rxd = 1'b1;
    if (good) begin
      if (exp_q.size() == 0) begin
        check_output("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp_byte = exp_q.pop_front();
        check_output("data_out", bus.data_out, exp_byte);
        check_output("data_ready", bus.data_ready, 1'b1);
      end
    end
  endtask

  initial begin
    int fe_before;
    reset = 1'b1;
    rxd = 1'b1;
    bus.data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("power_on");
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Clean byte.
    apply_stimulus(8'hA5, 1'b1, 1'b1, 1'b0, 0);
    check_output("clean_overrun", bus.overrun, 1'b0);
    check_output("clean_no_ferr", fe_pulses, 0);
    ack_byte();

    // Start glitch of 18 clk, then a real frame to show the FSM is idle again.
    fe_before = fe_pulses;
    @(posedge clk);
    while (rx_en !== 1'b1) @(posedge clk);
    #1 rxd = 1'b0;
    repeat (18) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (800) @(posedge clk);
    #1 check_output("glitch_no_ready", bus.data_ready, 1'b0);
    check_output("glitch_no_ferr", fe_pulses, fe_before);
    apply_stimulus(8'h96, 1'b1, 1'b1, 1'b0, 0);
    ack_byte();

    // Bad stop bit after a fresh reset.
    apply_reset();
    fe_before = fe_pulses;
    apply_stimulus(8'h3C, 1'b0, 1'b1, 1'b0, 0);
    check_output("badstop_data_out", bus.data_out, 8'h00);
    check_output("badstop_ready", bus.data_ready, 1'b0);
    check_output("badstop_pulse_count", fe_pulses, fe_before + 1);
    repeat (200) @(posedge clk);

    // Overrun.
    apply_stimulus(8'h11, 1'b1, 1'b1, 1'b0, 0);
    check_output("overrun_first_clear", bus.overrun, 1'b0);
    apply_stimulus(8'h22, 1'b1, 1'b0, 1'b0, 0);
    check_output("overrun_set", bus.overrun, 1'b1);
    ack_byte();

    // Publish and ack in the same cycle.
    apply_stimulus(8'h11, 1'b1, 1'b1, 1'b0, 0);
    apply_stimulus(8'h22, 1'b1, 1'b0, 1'b1, 0);
    check_output("simul_overrun", bus.overrun, 1'b0);
    ack_byte();

    // Back-to-back frames with no idle gap.
    apply_stimulus(8'h00, 1'b1, 1'b1, 1'b0, 0);
    apply_stimulus(8'hFF, 1'b1, 1'b0, 1'b0, 0);
    check_output("b2b_overrun", bus.overrun, 1'b1);

    // Reset during bit 4 of 0x5A while a byte is still pending.
    apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b0, 380);
    repeat (800) @(posedge clk);
    #1 check_reset_values("after_reset_idle");
    apply_stimulus(8'hC3, 1'b1, 1'b1, 1'b0, 0);
    ack_byte();

    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
